// File: rtl/ipm_var_delay_line_v2_0.sv
// Variable-depth delay line: MAX_DEPTH register stages per lane, output tapped at the
// active depth. Config loads flush the line; a small FILL/PRIMED FSM reports when it is full.
module ipm_var_delay_line_v2_0 #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNELS      = 1,
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DEPTH = 1,
    localparam int DW           = $clog2(MAX_DEPTH + 1),
    localparam int W            = CHANNELS * DATA_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_aclken,
    input  logic          i_valid,
    input  logic [W-1:0]  i_data,
    input  logic          i_cfg_vld,
    input  logic [DW-1:0] i_cfg_depth,
    output logic          o_valid,
    output logic [W-1:0]  o_data,
    output logic [DW-1:0] o_depth,
    output logic          o_primed,
    output logic          o_cfg_err
);

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_PRIMED = 1'b1
    } state_t;

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DEPTH);

    logic [MAX_DEPTH-1:0] vld_q, vld_d;
    logic [W-1:0]         data_q [MAX_DEPTH];
    logic [W-1:0]         data_d [MAX_DEPTH];
    logic [DW-1:0]        depth_q, depth_d;
    logic [DW-1:0]        fill_q, fill_d;
    state_t               state_q, state_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 cfg_legal;
    logic                 cfg_bad;
    logic [DW-1:0]        tap_sel;

    assign cfg_legal = i_cfg_vld && (i_cfg_depth != '0) && (i_cfg_depth <= MAX_D);
    assign cfg_bad   = i_cfg_vld && !cfg_legal;

    always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        depth_d   = depth_q;
        fill_d    = fill_q;
        state_d   = state_q;
        cfg_err_d = cfg_bad;

        if (i_aclken) begin
            vld_d[0]  = i_valid;
            data_d[0] = i_data;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                vld_d[i]  = vld_q[i-1];
                data_d[i] = data_q[i-1];
            end
            if (fill_q < depth_q) begin
                fill_d = fill_q + DW'(1);
            end
            if ((state_q == ST_FILL) && (fill_d == depth_q)) begin
                state_d = ST_PRIMED;
            end
        end

        // A legal load is a flush; a sample arriving on the same enabled cycle is kept.
        if (cfg_legal) begin
            depth_d = i_cfg_depth;
            fill_d  = '0;
            state_d = ST_FILL;
            vld_d   = '0;
            if (i_aclken) begin
                vld_d[0] = i_valid;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_q     <= '0;
            depth_q   <= DEF_D;
            fill_q    <= '0;
            state_q   <= ST_FILL;
            cfg_err_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            depth_q   <= depth_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Payload bits carry no reset; only the valid bits qualify them.
    always_ff @(posedge i_clk) begin
        data_q <= data_d;
    end

    assign tap_sel = depth_q - DW'(1);

    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (tap_sel == DW'(i)) begin
                o_valid = vld_q[i];
                o_data  = data_q[i];
            end
        end
    end

    assign o_depth   = depth_q;
    assign o_primed  = (state_q == ST_PRIMED);
    assign o_cfg_err = cfg_err_q;

endmodule

// File: doc/ipm_var_delay_line_v2_0.md
IPM_VAR_DELAY_LINE_V2_0 -- requirements
Module: ipm_var_delay_line_v2_0

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 1, independent lanes sharing one control path.
REQ-003 SHALL have parameter MAX_DEPTH, default 16, maximum delay in enabled cycles (>=1).
REQ-004 SHALL have parameter DEFAULT_DEPTH, default 1, depth after reset (1..MAX_DEPTH).
REQ-005 SHALL have i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have i_rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have i_aclken  input  1  clock enable for data path and fill counter.
REQ-008 SHALL have i_valid  input  1  qualifies i_data.
REQ-009 SHALL have i_data  input  CHANNELS*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have i_cfg_vld  input  1  one-cycle depth-load strobe.
REQ-011 SHALL have i_cfg_depth  input  DW=$clog2(MAX_DEPTH+1)  requested depth.
REQ-012 SHALL have o_valid  output  1  qualifies o_data.
REQ-013 SHALL have o_data  output  CHANNELS*DATA_WIDTH  delayed data.
REQ-014 SHALL have o_depth  output  DW  active depth.
REQ-015 SHALL have o_primed  output  1  line filled since last reset/config.
REQ-016 SHALL have o_cfg_err  output  1  one-cycle pulse, depth request rejected.

Function
REQ-017 SHALL hold MAX_DEPTH stages per lane plus one valid bit per stage; stage 0 loads {i_valid, i_data}, stage n loads stage n-1.
REQ-018 SHALL shift all stages only on cycles with i_aclken=1; with i_aclken=0 all stages, counter and outputs hold.
REQ-019 SHALL shift a bubble (valid=0, data don't-care) when i_aclken=1 and i_valid=0.
REQ-020 SHALL drive o_data/o_valid from stage o_depth-1 (mux of registers, no extra register); latency exactly o_depth enabled cycles.
REQ-021 SHALL treat i_cfg_depth in 1..MAX_DEPTH as legal: next cycle o_depth=i_cfg_depth, all stage valid bits cleared, fill counter cleared, state FILL.
REQ-022 SHALL treat i_cfg_depth=0 or >MAX_DEPTH as illegal: o_depth, stages and state unchanged, o_cfg_err=1 for exactly the next cycle.
REQ-023 SHALL accept i_cfg_vld regardless of i_aclken.
REQ-024 SHALL, on legal i_cfg_vld with i_aclken=1 in the same cycle, clear stages 1..MAX_DEPTH-1 and load stage 0 with the incoming {i_valid, i_data} (new sample survives).
REQ-025 SHALL implement states FILL and PRIMED: FILL->PRIMED when fill counter reaches o_depth; PRIMED->FILL only on legal config; o_primed=1 iff PRIMED.
REQ-026 SHALL increment the fill counter once per enabled cycle (valid or bubble), saturating at o_depth.
REQ-027 SHALL, for depth equal to current depth, still perform the full clear (config is a flush command).
REQ-028 SHALL treat lanes identically; no cross-lane data mixing.

Reset
REQ-029 SHALL on i_rst_n=0 at a rising edge: all valid bits 0, fill counter 0, o_depth=DEFAULT_DEPTH, state FILL, o_cfg_err=0, o_valid=0, o_primed=0.
REQ-030 SHALL let data bits be non-reset (reset only valid/control) for area; o_data undefined while o_valid=0.
REQ-031 SHALL give reset priority over i_cfg_vld and i_aclken in the same cycle.
REQ-032 SHALL, on reset mid-stream, drop all in-flight samples; no o_valid until new samples traverse DEFAULT_DEPTH.

Verification
REQ-033 SHALL cover: reset, DEFAULT_DEPTH=1, aclken=1, i_data=0x5A valid -> o_valid=1, o_data=0x5A next cycle, o_primed=1.
REQ-034 SHALL cover: cfg depth=4, samples 1,2,3,4 every cycle -> sample 1 at o_data 4 cycles after entry; o_primed rises after 4th enabled cycle.
REQ-035 SHALL cover: depth=4, i_aclken low 3 cycles mid-stream -> outputs frozen, sample order and count preserved, latency 4 enabled cycles.
REQ-036 SHALL cover: cfg depth=0 then depth=MAX_DEPTH+1 -> o_cfg_err single-cycle pulse each, o_depth unchanged, data flow uninterrupted.
REQ-037 SHALL cover: cfg depth=8 same cycle as valid 0xA5 with aclken=1 -> older samples discarded, 0xA5 emerges after 8 enabled cycles, no other o_valid before it.
REQ-038 SHALL cover: CHANNELS=3, distinct per-lane patterns, i_rst_n low mid-stream -> o_valid=0 next cycle, lanes never swapped.
